// File: rtl/game_controller.sv
// Turn/move sequencer between the cursor/input logic and the chess board datapath.
// It validates origin/destination ownership against board memory and issues one move per turn.
module game_controller #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [25:0] DONE_TIMEOUT = 26'd1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic       select,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  input  logic [3:0] board_piece,
  input  logic       initialize_complete,
  input  logic       move_complete,
  output logic       initialize_board,
  output logic       move_piece,
  output logic [2:0] origin_x,
  output logic [2:0] origin_y,
  output logic [2:0] destination_x,
  output logic [2:0] destination_y,
  output logic [3:0] piece_to_move,
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  output logic       current_player,
  output logic       origin_selected,
  output logic       game_over,
  output logic       error,
  output logic [3:0] fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_SEL_ORIGIN, S_RD_ORIGIN,
    S_SEL_DEST, S_RD_DEST, S_MOVE_REQ, S_MOVE_WAIT, S_GAME_OVER
  } state_t;

  localparam logic [25:0] RD_WAIT      = 26'(READ_LATENCY);
  localparam logic [25:0] TIMEOUT_LAST = DONE_TIMEOUT - 26'd1;

  state_t      state, state_next;
  logic [25:0] cnt, cnt_next;
  logic        capture_king, capture_king_next;
  logic [2:0]  origin_x_next, origin_y_next, destination_x_next, destination_y_next;
  logic [2:0]  rd_x_next, rd_y_next;
  logic [3:0]  piece_to_move_next;
  logic        current_player_next, origin_selected_next, game_over_next, error_next;

  function automatic logic is_own(input logic player, input logic [3:0] p);
    is_own = player ? (p >= 4'd1 && p <= 4'd6) : (p >= 4'd7 && p <= 4'd12);
  endfunction

  assign fsm_state        = state;
  assign initialize_board = (state == S_INIT_REQ);
  assign move_piece       = (state == S_MOVE_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      capture_king    <= 1'b0;
      origin_x        <= '0;
      origin_y        <= '0;
      destination_x   <= '0;
      destination_y   <= '0;
      piece_to_move   <= '0;
      rd_x            <= '0;
      rd_y            <= '0;
      current_player  <= 1'b0;
      origin_selected <= 1'b0;
      game_over       <= 1'b0;
      error           <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      capture_king    <= capture_king_next;
      origin_x        <= origin_x_next;
      origin_y        <= origin_y_next;
      destination_x   <= destination_x_next;
      destination_y   <= destination_y_next;
      piece_to_move   <= piece_to_move_next;
      rd_x            <= rd_x_next;
      rd_y            <= rd_y_next;
      current_player  <= current_player_next;
      origin_selected <= origin_selected_next;
      game_over       <= game_over_next;
      error           <= error_next;
    end
  end

  // One counter serves both the read-latency wait and the datapath timeout;
  // it is zeroed on entry to each waiting state and saturates.
  always_comb begin
    state_next           = state;
    cnt_next             = (&cnt) ? cnt : cnt + 26'd1;
    capture_king_next    = capture_king;
    origin_x_next        = origin_x;
    origin_y_next        = origin_y;
    destination_x_next   = destination_x;
    destination_y_next   = destination_y;
    piece_to_move_next   = piece_to_move;
    rd_x_next            = rd_x;
    rd_y_next            = rd_y;
    current_player_next  = current_player;
    origin_selected_next = origin_selected;
    game_over_next       = game_over;
    error_next           = error;
    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start_game) begin
          error_next           = 1'b0;
          game_over_next       = 1'b0;
          current_player_next  = 1'b0;
          origin_selected_next = 1'b0;
          state_next           = S_INIT_REQ;
        end
      end
      S_INIT_REQ: begin
        cnt_next   = '0;
        state_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (initialize_complete) begin
          state_next = S_SEL_ORIGIN;
        end else if (cnt == TIMEOUT_LAST) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SEL_ORIGIN: begin
        rd_x_next = cursor_x;
        rd_y_next = cursor_y;
        if (select) begin
          origin_x_next = cursor_x;
          origin_y_next = cursor_y;
          cnt_next      = '0;
          state_next    = S_RD_ORIGIN;
        end
      end
      S_RD_ORIGIN: begin
        if (cnt == RD_WAIT) begin
          if (is_own(current_player, board_piece)) begin
            piece_to_move_next   = board_piece;
            origin_selected_next = 1'b1;
            state_next           = S_SEL_DEST;
          end else begin
            state_next = S_SEL_ORIGIN;
          end
        end
      end
      S_SEL_DEST: begin
        rd_x_next = cursor_x;
        rd_y_next = cursor_y;
        if (select) begin
          if (cursor_x == origin_x && cursor_y == origin_y) begin
            origin_selected_next = 1'b0;
            state_next           = S_SEL_ORIGIN;
          end else begin
            destination_x_next = cursor_x;
            destination_y_next = cursor_y;
            cnt_next           = '0;
            state_next         = S_RD_DEST;
          end
        end
      end
      S_RD_DEST: begin
        if (cnt == RD_WAIT) begin
          if (is_own(current_player, board_piece)) begin
            state_next = S_SEL_DEST;
          end else begin
            capture_king_next = (board_piece == 4'd6) || (board_piece == 4'd12);
            state_next        = S_MOVE_REQ;
          end
        end
      end
      S_MOVE_REQ: begin
        cnt_next   = '0;
        state_next = S_MOVE_WAIT;
      end
      S_MOVE_WAIT: begin
        if (move_complete) begin
          origin_selected_next = 1'b0;
          if (capture_king) begin
            game_over_next = 1'b1;
            state_next     = S_GAME_OVER;
          end else begin
            current_player_next = ~current_player;
            state_next          = S_SEL_ORIGIN;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          error_next           = 1'b1;
          origin_selected_next = 1'b0;
          state_next           = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: transaction-level game model with a bench-owned board memory,
// directed scenarios followed by randomized play, timeouts and a mid-read reset.
module tb_game_controller;
  localparam int RL = 2;
  localparam int DT = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_game, select, initialize_complete, move_complete;
  logic [2:0] cursor_x, cursor_y, origin_x, origin_y, destination_x, destination_y, rd_x, rd_y;
  logic [3:0] board_piece, piece_to_move, fsm_state;
  logic       initialize_board, move_piece, current_player, origin_selected, game_over, error;

  game_controller #(.READ_LATENCY(RL), .DONE_TIMEOUT(26'(DT))) dut (
    .clk(clk), .reset(reset), .start_game(start_game), .select(select),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .board_piece(board_piece),
    .initialize_complete(initialize_complete), .move_complete(move_complete),
    .initialize_board(initialize_board), .move_piece(move_piece),
    .origin_x(origin_x), .origin_y(origin_y),
    .destination_x(destination_x), .destination_y(destination_y),
    .piece_to_move(piece_to_move), .rd_x(rd_x), .rd_y(rd_y),
    .current_player(current_player), .origin_selected(origin_selected),
    .game_over(game_over), .error(error), .fsm_state(fsm_state)
  );

  // Board memory stub: RL-stage read pipeline addressed by rd_y/rd_x.
  logic [3:0] board [64];
  logic [3:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= board[{rd_y, rd_x}];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign board_piece = pipe[RL-1];

  typedef enum {P_IDLE, P_ORIGIN, P_DEST, P_MOVING, P_OVER} phase_t;
  phase_t      m_phase;
  logic        m_player, m_osel, m_over, m_err, m_king;
  logic [2:0]  m_ox, m_oy, m_dx, m_dy;
  logic [3:0]  m_piece;
  logic [15:0] exp_q[$];
  logic [15:0] last_move;
  int          exp_inits, init_seen;
  int          n_pass, n_checks;
  bit          chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit own(input logic player, input logic [3:0] p);
    int v = int'(p);
    if (player) return (v >= 1 && v <= 6);
    return (v >= 7 && v <= 12);
  endfunction

  function automatic void board_setup();
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    for (int x = 0; x < 8; x++) begin
      board[x]      = 4'(back[x]);
      board[8 + x]  = 4'd1;
      board[48 + x] = 4'd7;
      board[56 + x] = 4'(back[x] + 6);
    end
  endfunction

  function automatic int find_square(input bit want_own);
    int q[$];
    for (int i = 0; i < 64; i++)
      if (own(m_player, board[i]) == want_own) q.push_back(i);
    if (q.size() == 0) return int'($urandom_range(0, 63));
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_player = 0; m_osel = 0; m_over = 0; m_err = 0; m_king = 0;
    m_ox = 0; m_oy = 0; m_dx = 0; m_dy = 0; m_piece = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse, monitor and per-cycle comparison against the model once it has settled.
  always @(negedge clk) begin
    if (initialize_board) init_seen++;
    if (move_piece) begin
      last_move = {origin_x, origin_y, destination_x, destination_y, piece_to_move};
      chk("move_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("move_fields", 32'(last_move), 32'(exp_q.pop_front()));
    end
    if (chk_en) begin
      chk("current_player", 32'(current_player), 32'(m_player));
      chk("game_over", 32'(game_over), 32'(m_over));
      chk("error", 32'(error), 32'(m_err));
      chk("origin_selected", 32'(origin_selected), 32'(m_osel));
      chk("origin", 32'({origin_x, origin_y}), 32'({m_ox, m_oy}));
      chk("destination", 32'({destination_x, destination_y}), 32'({m_dx, m_dy}));
      chk("piece_to_move", 32'(piece_to_move), 32'(m_piece));
      chk("initialize_board_idle", 32'(initialize_board), 0);
      chk("move_piece_idle", 32'(move_piece), 0);
      if (m_phase == P_ORIGIN || m_phase == P_DEST)
        chk("rd_follows_cursor", 32'({rd_x, rd_y}), 32'({cursor_x, cursor_y}));
    end
  end

  task automatic do_start(input bit complete, input int delay);
    bit accepted;
    chk_en = 0;
    accepted = (m_phase == P_IDLE || m_phase == P_OVER);
    start_game = 1; tick(1); start_game = 0;
    if (accepted) begin
      exp_inits++; m_err = 0; m_over = 0; m_player = 0; m_osel = 0;
      board_setup();
      if (complete) begin
        tick(delay);
        initialize_complete = 1; tick(1); initialize_complete = 0;
        tick(2);
        m_phase = P_ORIGIN;
      end else begin
        tick(DT - 6);
        chk("init_no_early_timeout", 32'(error), 0);
        tick(12);
        chk("init_timeout_error", 32'(error), 1);
        m_err = 1; m_phase = P_IDLE;
      end
    end else begin
      tick(3);
    end
    chk_en = 1;
  endtask

  task automatic pick(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] p;
    chk_en = 0;
    p = board[{y, x}];
    case (m_phase)
      P_ORIGIN: begin
        m_ox = x; m_oy = y;
        if (own(m_player, p)) begin m_piece = p; m_osel = 1; m_phase = P_DEST; end
      end
      P_DEST: begin
        if (x == m_ox && y == m_oy) begin
          m_osel = 0; m_phase = P_ORIGIN;
        end else begin
          m_dx = x; m_dy = y;
          if (!own(m_player, p)) begin
            m_king = (p == 4'd6 || p == 4'd12);
            m_phase = P_MOVING;
            exp_q.push_back({m_ox, m_oy, x, y, m_piece});
          end
        end
      end
      default: ;
    endcase
    cursor_x = x; cursor_y = y; select = 1; tick(1); select = 0;
    tick(RL + 4);
    chk_en = 1;
  endtask

  task automatic pick_idx(input int idx);
    pick(3'(idx % 8), 3'(idx / 8));
  endtask

  task automatic finish_move(input int delay);
    chk_en = 0;
    tick(delay);
    move_complete = 1; tick(1); move_complete = 0;
    if (m_phase == P_MOVING) begin
      board[{m_dy, m_dx}] = m_piece;
      board[{m_oy, m_ox}] = 4'd0;
      m_osel = 0;
      if (m_king) begin m_over = 1; m_phase = P_OVER; end
      else begin m_player = ~m_player; m_phase = P_ORIGIN; end
    end
    tick(2);
    chk_en = 1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_initialize_board"}, 32'(initialize_board), 0);
    chk({tag, "_move_piece"}, 32'(move_piece), 0);
    chk({tag, "_origin"}, 32'({origin_x, origin_y}), 0);
    chk({tag, "_destination"}, 32'({destination_x, destination_y}), 0);
    chk({tag, "_piece_to_move"}, 32'(piece_to_move), 0);
    chk({tag, "_rd"}, 32'({rd_x, rd_y}), 0);
    chk({tag, "_flags"}, 32'({current_player, origin_selected, game_over, error}), 0);
  endtask

  task automatic get_to_origin();
    if (m_phase == P_OVER || m_phase == P_IDLE) do_start(1, 5);
    if (m_phase == P_DEST) pick(m_ox, m_oy);
  endtask

  initial begin
    n_pass = 0; n_checks = 0; exp_inits = 0; init_seen = 0; chk_en = 0;
    reset = 1; start_game = 0; select = 0; initialize_complete = 0; move_complete = 0;
    cursor_x = 0; cursor_y = 0;
    model_reset(); board_setup();
    tick(3);
    check_all_zero("reset");
    reset = 0; tick(1); chk_en = 1;

    // Directed opening.
    do_start(1, 64);
    chk("init_pulse_once", 32'(init_seen), 1);
    chk("player_after_init", 32'(current_player), 0);
    pick(0, 1);
    chk("enemy_origin_no_select", 32'(origin_selected), 0);
    chk("enemy_origin_latched", 32'({origin_x, origin_y}), 32'({3'd0, 3'd1}));
    pick(4, 6);
    chk("pawn_origin_selected", 32'(origin_selected), 1);
    chk("pawn_piece", 32'(piece_to_move), 7);
    pick(4, 4);
    chk("first_move_literal", 32'(last_move), 32'({3'd4, 3'd6, 3'd4, 3'd4, 4'd7}));
    finish_move(64);
    chk("player_after_move", 32'(current_player), 1);
    pick(0, 1);
    pick(1, 0);
    chk("own_dest_still_selected", 32'(origin_selected), 1);
    pick(0, 1);
    chk("cancel_clears_select", 32'(origin_selected), 0);
    pick(0, 1); pick(0, 2); finish_move(10);
    pick(4, 4); pick(4, 0); finish_move(20);
    chk("king_capture_game_over", 32'(game_over), 1);
    pick(3, 6);
    chk("select_ignored_when_over", 32'({origin_x, origin_y, origin_selected}), 32'({3'd4, 3'd4, 1'b0}));
    do_start(1, 30);
    chk("restart_clears_game_over", 32'(game_over), 0);
    chk("restart_init_pulses", 32'(init_seen), 2);

    // Randomized play.
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 80; n++) begin
        if (m_phase != P_ORIGIN && m_phase != P_DEST) break;
        if ($urandom_range(0, 19) == 0) do_start(1, 0);
        if (m_phase == P_ORIGIN) begin
          if ($urandom_range(0, 9) < 7) pick_idx(find_square(1));
          else pick_idx(int'($urandom_range(0, 63)));
        end else begin
          int r = int'($urandom_range(0, 9));
          if (r < 2) pick(m_ox, m_oy);
          else if (r < 4) pick_idx(find_square(1));
          else pick_idx(find_square(0));
        end
        if (m_phase == P_MOVING) begin
          if ($urandom_range(0, 9) < 3) pick_idx(int'($urandom_range(0, 63)));
          finish_move(int'($urandom_range(1, 64)));
        end
      end
      if (m_phase == P_OVER) do_start(1, int'($urandom_range(1, 64)));
    end

    // Datapath never completes the move.
    get_to_origin();
    pick_idx(find_square(1));
    pick_idx(find_square(0));
    chk_en = 0;
    tick(DT - 8);
    chk("move_no_early_timeout", 32'(error), 0);
    tick(16);
    chk("move_timeout_error", 32'(error), 1);
    m_err = 1; m_osel = 0; m_phase = P_IDLE;
    tick(1); chk_en = 1; tick(3);

    // Init timeout, then a restart clears the error.
    do_start(0, 0);
    do_start(1, 64);
    chk("restart_clears_error", 32'(error), 0);

    // Reset while the destination read is in flight.
    pick_idx(find_square(1));
    if (m_phase == P_DEST) begin
      int d = find_square(0);
      chk_en = 0;
      cursor_x = 3'(d % 8); cursor_y = 3'(d / 8); select = 1; tick(1); select = 0;
      reset = 1; tick(1);
      check_all_zero("mid_read_reset");
      reset = 0; model_reset(); tick(2); chk_en = 1;
      do_start(1, 10);
    end
    tick(4);

    chk("init_pulse_count", 32'(init_seen), 32'(exp_inits));
    chk("no_pending_moves", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
